// File: rtl/pushbuttons_leds_debounced.sv
// N-channel pushbutton-to-LED block: 2-flop synchroniser, per-channel debounce counter,
// follow/toggle LED drive and one-cycle press/release pulses. Toggle mode needs PB_LEDS_TOGGLE_EN.
module pushbuttons_leds_debounced #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_n_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] led_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  s1_q, s1_d;
  logic [N_CH-1:0]  s2_q, s2_d;
  logic [N_CH-1:0]  db_q, db_d;
  logic [N_CH-1:0]  press_q, press_d;
  logic [N_CH-1:0]  release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d  = ~pb_n_i;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d   = db_d & ~db_q;
    release_d = ~db_d & db_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef PB_LEDS_TOGGLE_EN
  logic [N_CH-1:0] tog_q, tog_d;

  // In follow mode tog tracks db, which makes the follow->toggle switch bumpless and
  // lets tog drive the LED in both modes.
  always_comb begin
    tog_d = tog_q;
    for (int i = 0; i < N_CH; i++) begin
      tog_d[i] = mode_i[i] ? (tog_q[i] ^ press_d[i]) : db_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tog_q <= '0;
    else        tog_q <= tog_d;
  end

  assign led_o = tog_q;
`else
  logic unused_mode;
  assign unused_mode = ^mode_i;
  assign led_o       = db_q;
`endif

endmodule

// File: doc/pushbuttons_leds_debounced.md
# pushbuttons_leds_debounced

Parametrised N-channel pushbutton-to-LED block for the LogiPi board: synchronises active-low pushbutton pins, debounces each channel with a per-channel stability counter, and drives one LED per channel either following the button or toggling on each press. Sits directly between the board button pins and the LED pins, and also exports one-cycle press/release pulses for downstream logic.

## Interface
- `N_CH`, 2, number of button/LED channels (≥1)
- `DEBOUNCE_CYCLES`, 50000, clock cycles a new level must be stable before acceptance (≥2; 1 ms at 50 MHz)
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`, debounce counter width (derived, not overridden)

Ports:
- `clk`  in  1  system clock; everything is on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `pb_n`  in  N_CH  raw pushbutton pins, active-low, asynchronous to `clk`
- `mode`  in  N_CH  per-channel mode: 0 = follow, 1 = toggle
- `led`  out  N_CH  LED drive, active-high, registered
- `press`  out  N_CH  one-cycle pulse on accepted press
- `release`  out  N_CH  one-cycle pulse on accepted release

## Operation
- Per channel i:
  - Invert `pb_n[i]`.
  - 2-flop synchroniser: `s1`, then `s2`.
  - Debounced state `db[i]`, counter `cnt[i]`, toggle register `tog[i]`.
- Reset (`rst_n`=0 at an edge): `s1`, `s2`, `db`, `cnt`, `tog`, `led`, `press`, `release` all cleared to 0 (released, LEDs off). Reset asserted mid-count discards the count.
- Debounce, each edge:
  - `s2`==`db`: `cnt`<=0.
  - `s2`!=`db` and `cnt`<DEBOUNCE_CYCLES-1: `cnt`<=`cnt`+1.
  - `s2`!=`db` and `cnt`==DEBOUNCE_CYCLES-1: `db`<=`s2`, `cnt`<=0.
  - `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- `press[i]` is registered. It is 1 for exactly the cycle following the edge where `db` goes 0→1. `release[i]` is the same for a 1→0 transition. Otherwise both are 0.
- Follow mode (`mode[i]`=0): `tog[i]`<=`db` next value each edge; `led[i]` equals `db[i]`.
- Toggle mode (`mode[i]`=1): `tog[i]` flips on the edge where `db` goes 0→1 and holds otherwise; `led[i]` equals `tog[i]`. Release does not affect it.
- Mode switch is bumpless: switching follow→toggle keeps the LED at the current `db` value; switching toggle→follow shows `db` from the next cycle.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.
- `mode` is sampled every edge and needs no synchronisation. It is a static or `clk`-domain input.

## Timing
- Latency: `pb_n[i]` is held low from before edge 0. Then `s2`=1 after edge 1 and `db`/`led` (follow) =1 after edge DEBOUNCE_CYCLES+1. `press` is high in the cycle after edge DEBOUNCE_CYCLES+1. A toggle-mode `led` flips at that same edge.
- Release has the same latency, counted from the first edge sampling `pb_n` high.
- Any level held for fewer than DEBOUNCE_CYCLES consecutive `s2` cycles is filtered out: there is no `db` change and no pulse. A return to the old level resets `cnt` to 0.
- Maximum output rate: one `press` or `release` per DEBOUNCE_CYCLES cycles per channel.
- Outputs are valid from the first edge after reset deasserts. No handshakes.

## Configuration
- `PB_LEDS_TOGGLE_EN`:
  - Defined: toggle mode and `tog` registers are present, as described above.
  - Undefined: `tog` logic is removed; the `mode` port remains but is ignored, and `led[i]` always equals `db[i]`. `press`/`release` are unchanged.

## Test plan
- Reset: N_CH=2, DEBOUNCE_CYCLES=4, `rst_n`=0 for 3 cycles with `pb_n`=2'b00 -> `led`=0, `press`=0, `release`=0 during reset; after release, `led[0]` rises at edge 5 after the first sampling edge.
- Clean press, follow mode: `pb_n[0]` low from edge 0 -> `led[0]`=1 after edge 5; `press[0]`=1 for exactly 1 cycle; `led[1]` stays 0.
- Bounce filter: `pb_n[0]` low for 3 cycles, high for 1, low for 3, then high -> `led`, `press`, `release` stay 0 throughout.
- Toggle mode (macro defined): `mode`=2'b01, three clean press/release pairs on ch0 -> `led[0]` goes 1, 0, 1; each flip coincides with a `press[0]` pulse; `release[0]` pulses 3 times.
- Simultaneous channels and mid-count reset: both buttons pressed at edge 0, `rst_n`=0 at edge 3 for 1 cycle -> no pulse before edge 5. After reset, both `led` bits rise on the same edge, DEBOUNCE_CYCLES+1 edges after re-sampling.
- Macro undefined: `mode`=2'b11 with a clean press on ch1 -> `led[1]` follows `db[1]` (1 while held, 0 after release) and does not toggle.
